// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing the DMI master port between the JTAG DTM (port 0)
// and the register-dump/replay engine (port 1). It handles one command at a time.
//
// state | meaning
// IDLE  | waiting for a request; ready is asserted to the selected port
// ISSUE | one-cycle dmi_rd/dmi_wr strobe from the latched command
// WAIT  | holding addr/wdata until dmi_ack or the timeout
// RESP  | one-cycle response pulse to the granted port
module dmi_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              dmi_rd,
    output logic              dmi_wr,
    output logic [ADDR_W-1:0] dmi_addr,
    output logic [DATA_W-1:0] dmi_wdata,
    input  logic [DATA_W-1:0] dmi_rdata,
    input  logic              dmi_ack
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              last_grant;
    logic              grant;
    logic              lat_wr;
    logic [TW-1:0]     timer;

    logic              sel;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // On a tie the port that did not win last time is selected.
    assign sel        = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = (state == IDLE) && req0_valid && !sel;
    assign req1_ready = (state == IDLE) && req1_valid && sel;

    assign acc_wr    = sel ? req1_wr    : req0_wr;
    assign acc_addr  = sel ? req1_addr  : req0_addr;
    assign acc_wdata = sel ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_wr     <= 1'b0;
            timer      <= '0;
            dmi_rd     <= 1'b0;
            dmi_wr     <= 1'b0;
            dmi_addr   <= '0;
            dmi_wdata  <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        grant     <= sel;
                        lat_wr    <= acc_wr;
                        dmi_wr    <= acc_wr;
                        dmi_rd    <= !acc_wr;
                        dmi_addr  <= acc_addr;
                        dmi_wdata <= acc_wr ? acc_wdata : '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    dmi_rd <= 1'b0;
                    dmi_wr <= 1'b0;
                    timer  <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // An ack on the last timeout cycle still completes normally.
                    if (dmi_ack || timer == T_LAST) begin
                        if (grant) begin
                            rsp1_valid <= 1'b1;
                            rsp1_rdata <= (dmi_ack && !lat_wr) ? dmi_rdata : '0;
                            rsp1_err   <= !dmi_ack;
                        end else begin
                            rsp0_valid <= 1'b1;
                            rsp0_rdata <= (dmi_ack && !lat_wr) ? dmi_rdata : '0;
                            rsp0_err   <= !dmi_ack;
                        end
                        dmi_addr  <= '0;
                        dmi_wdata <= '0;
                        state     <= RESP;
                    end else if (timer != T_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    rsp0_valid <= 1'b0;
                    rsp0_rdata <= '0;
                    rsp0_err   <= 1'b0;
                    rsp1_valid <= 1'b0;
                    rsp1_rdata <= '0;
                    rsp1_err   <= 1'b0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed scenarios plus randomized commands checked
// against a transaction-level model of arbitration, latency and timeout.
module tb_dmi_arbiter;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk, rst_n;
    logic          req0_valid, req0_ready, req0_wr;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid, rsp0_err;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_ready, req1_wr;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid, rsp1_err;
    logic [DW-1:0] rsp1_rdata;
    logic          dmi_rd, dmi_wr, dmi_ack;
    logic [AW-1:0] dmi_addr;
    logic [DW-1:0] dmi_wdata, dmi_rdata;

    dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .dmi_rd(dmi_rd), .dmi_wr(dmi_wr), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
        .dmi_rdata(dmi_rdata), .dmi_ack(dmi_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    bit m_last = 1'b1;     // model: port granted most recently
    int last_acc = -100;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got hang want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [137:0] all_outputs();
        return {req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
                req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
                dmi_rd, dmi_wr, dmi_addr, dmi_wdata};
    endfunction

    // One complete command. dly = WAIT cycle index at which the DM acks
    // (>= TO means no ack); the model derives grant, strobe and response.
    task automatic run_cmd(input bit v0, input bit v1, input bit w0, input bit w1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input int dly, input logic [DW-1:0] rd, input string tag);
        bit            eg, ewr, eerr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, erd;
        int            nwait;
        logic [40:0]   exp_iss;
        logic [67:0]   exp_rsp, got_rsp;
        logic [1:0]    exp_rdy;

        eg  = (v0 && v1) ? !m_last : v1;
        ewr = eg ? w1 : w0;
        ea  = eg ? a1 : a0;
        ewd = ewr ? (eg ? d1 : d0) : '0;
        if (dly < TO) begin
            eerr = 1'b0; erd = ewr ? '0 : rd; nwait = dly + 1;
        end else begin
            eerr = 1'b1; erd = '0; nwait = TO;
        end

        req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wdata = d1;
        #1;
        exp_rdy = eg ? 2'b10 : 2'b01;
        checks++;
        if ({req1_ready, req0_ready} !== exp_rdy)
            $display("FAIL %s grant: ready got %b want %b", tag, {req1_ready, req0_ready}, exp_rdy);
        else passes++;
        checks++;
        if (cyc - last_acc < 4)
            $display("FAIL %s spacing: accept gap got %0d want >=4", tag, cyc - last_acc);
        else passes++;
        last_acc = cyc;

        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_iss = {!ewr, ewr, ea, ewd};
        checks++;
        if ({dmi_rd, dmi_wr, dmi_addr, dmi_wdata} !== exp_iss)
            $display("FAIL %s issue: strobe/addr/wdata got %h want %h", tag,
                     {dmi_rd, dmi_wr, dmi_addr, dmi_wdata}, exp_iss);
        else passes++;
        dmi_ack = 1'($urandom_range(0, 1));    // ack during ISSUE must be ignored
        dmi_rdata = $urandom;

        step();
        dmi_ack = 1'b0;
        for (int k = 0; k < nwait; k++) begin
            checks++;
            if (dmi_rd || dmi_wr || rsp0_valid || rsp1_valid || req0_ready || req1_ready ||
                dmi_addr !== ea || dmi_wdata !== ewd)
                $display("FAIL %s wait%0d: rd=%b wr=%b rsp=%b%b addr=%h wd=%h want 0,0,00 addr=%h wd=%h",
                         tag, k, dmi_rd, dmi_wr, rsp0_valid, rsp1_valid, dmi_addr, dmi_wdata, ea, ewd);
            else passes++;
            if (k == dly) begin dmi_ack = 1'b1; dmi_rdata = rd; end
            else dmi_rdata = $urandom;
            step();
            dmi_ack = 1'b0;
        end

        exp_rsp = eg ? {1'b0, 32'h0, 1'b0, 1'b1, erd, eerr} : {1'b1, erd, eerr, 1'b0, 32'h0, 1'b0};
        got_rsp = {rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid, rsp1_rdata, rsp1_err};
        checks++;
        if (got_rsp !== exp_rsp || dmi_addr !== '0 || dmi_wdata !== '0)
            $display("FAIL %s resp: rsp got %h want %h, addr=%h wd=%h want 0", tag,
                     got_rsp, exp_rsp, dmi_addr, dmi_wdata);
        else passes++;
        m_last = eg;
        dmi_ack = 1'($urandom_range(0, 1));    // unsolicited ack in RESP
        dmi_rdata = $urandom;

        step();
        dmi_ack = 1'b0;
        checks++;
        if (all_outputs() !== '0)
            $display("FAIL %s idle_after: outputs got %h want 0", tag, all_outputs());
        else passes++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_last = 1'b1;
        step();
    endtask

    task automatic test_reset();
        req0_valid = 0; req0_wr = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_wr = 0; req1_addr = '0; req1_wdata = '0;
        dmi_ack = 0; dmi_rdata = '0;
        rst_n = 1'b0;
        #3;
        checks++;
        if (all_outputs() !== '0) $display("FAIL reset_state: outputs got %h want 0", all_outputs());
        else passes++;
        apply_reset();
    endtask

    task automatic test_single_read();
        run_cmd(1, 0, 0, 0, 7'h11, 7'h00, 32'h0, 32'h0, 0, 32'hDEADBEEF, "read_p0");
    endtask

    task automatic test_write_p1();
        run_cmd(0, 1, 0, 1, 7'h00, 7'h10, 32'h0, 32'h80000001, 4, 32'h12345678, "write_p1");
    endtask

    task automatic test_contention();
        bit exp_port;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            exp_port = i[0];
            checks++;
            if (m_last === exp_port)
                $display("FAIL contention_order%0d: model last got %0d want %0d", i, m_last, !exp_port);
            else passes++;
            run_cmd(1, 1, 1'($urandom), 1'($urandom), 7'($urandom), 7'($urandom),
                    $urandom, $urandom, $urandom_range(0, 3), $urandom, "contention");
        end
    endtask

    task automatic test_timeout();
        run_cmd(1, 0, 0, 0, 7'h22, 7'h00, 32'h0, 32'h0, 100, 32'hCAFEF00D, "timeout");
        dmi_ack = 1'b1; dmi_rdata = 32'hBAD0BAD0;   // late ack arriving in IDLE
        step();
        dmi_ack = 1'b0;
        checks++;
        if (all_outputs() !== '0) $display("FAIL late_ack: outputs got %h want 0", all_outputs());
        else passes++;
        run_cmd(0, 1, 0, 0, 7'h00, 7'h23, 32'h0, 32'h0, 1, 32'h0000ABCD, "after_late_ack");
    endtask

    task automatic test_ack_last_cycle();
        run_cmd(1, 0, 0, 0, 7'h33, 7'h00, 32'h0, 32'h0, TO - 1, 32'h5, "ack_last");
    endtask

    task automatic test_reset_in_wait();
        req0_valid = 1; req0_wr = 0; req0_addr = 7'h44;
        #1;
        step();
        req0_valid = 0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_outputs() !== '0) $display("FAIL reset_in_wait: outputs got %h want 0", all_outputs());
        else passes++;
        step();
        step();
        rst_n = 1'b1;
        m_last = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (rsp0_valid || rsp1_valid || dmi_rd || dmi_wr)
                $display("FAIL reset_no_rsp%0d: rsp=%b%b strobes=%b%b want 0", i,
                         rsp0_valid, rsp1_valid, dmi_rd, dmi_wr);
            else passes++;
        end
        run_cmd(1, 1, 0, 1, 7'h45, 7'h46, 32'h0, 32'h77, 2, 32'h0BADCAFE, "tie_after_reset");
    endtask

    task automatic test_random();
        bit v0, v1;
        for (int i = 0; i < 30; i++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_cmd(v0, v1, 1'($urandom), 1'($urandom), 7'($urandom), 7'($urandom),
                    $urandom, $urandom, $urandom_range(0, 11), $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_p1();
        test_contention();
        test_timeout();
        test_ack_last_cycle();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
